// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter with port-B result FIFO and pending-register scoreboard
module rf_wb_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  hz_rs1,
    input  logic [4:0]  hz_rs2,
    input  logic [4:0]  hz_rd,
    output logic        hz_stall,
    output logic        starve_req,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    addr_mem_q [FIFO_DEPTH];
    logic [31:0]   data_mem_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          b_ready_q, b_ready_d;
    logic [31:0]   pending_q, pending_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          starve_q, starve_d;

    logic          a_eff;
    logic          fifo_empty;
    logic          pop_en;
    logic          push_en;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;

    assign a_eff      = a_valid & (a_addr != 5'd0);
    assign fifo_empty = (count_q == '0);
    assign head_addr  = addr_mem_q[rd_ptr_q];
    assign head_data  = data_mem_q[rd_ptr_q];
    assign pop_en     = ~a_eff & ~fifo_empty;
    // A full FIFO still takes a push in a cycle where the head drains.
    assign push_en    = b_valid & (b_ready_q | pop_en);

    assign b_ready    = b_ready_q;
    assign starve_req = starve_q;

    always_comb begin
        rf_we = 1'b0;
        rf_wa = 5'd0;
        rf_wd = 32'd0;
        if (a_eff) begin
            rf_we = 1'b1;
            rf_wa = a_addr;
            rf_wd = a_data;
        end else if (pop_en) begin
            rf_we = (head_addr != 5'd0);
            rf_wa = head_addr;
            rf_wd = head_data;
        end
    end

    always_comb begin
        hz_stall = 1'b0;
        if (hz_rs1 != 5'd0 && pending_q[hz_rs1]) hz_stall = 1'b1;
        if (hz_rs2 != 5'd0 && pending_q[hz_rs2]) hz_stall = 1'b1;
        if (hz_rd  != 5'd0 && pending_q[hz_rd])  hz_stall = 1'b1;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (push_en && !pop_en) begin
            count_d = count_q + 1'b1;
        end else if (pop_en && !push_en) begin
            count_d = count_q - 1'b1;
        end
        b_ready_d = (count_d != CW'(FIFO_DEPTH));
    end

    // Set after clear so a same-cycle issue to a committing register keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (pop_en && head_addr != 5'd0) begin
            pending_d[head_addr] = 1'b0;
        end
        if (iss_valid && iss_rd != 5'd0) begin
            pending_d[iss_rd] = 1'b1;
        end
    end

    always_comb begin
        starve_cnt_d = '0;
        if (!fifo_empty && a_eff) begin
            starve_cnt_d = (starve_cnt_q == SW'(STARVE_LIMIT)) ? starve_cnt_q
                                                               : starve_cnt_q + 1'b1;
        end
        starve_d = (starve_cnt_d >= SW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            b_ready_q    <= 1'b1;
            pending_q    <= '0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            b_ready_q    <= b_ready_d;
            pending_q    <= pending_d;
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            addr_mem_q[wr_ptr_q] <= b_addr;
            data_mem_q[wr_ptr_q] <= b_data;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - randomized self-checking bench for rf_wb_arbiter against a queue-based model
module tb_rf_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  hz_rs1;
    logic [4:0]  hz_rs2;
    logic [4:0]  hz_rd;
    logic        hz_stall;
    logic        starve_req;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    int checks   = 0;
    int failures = 0;

    logic [36:0] mq[$];
    bit   [31:0] pend;
    int          scnt;

    rf_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_rd(hz_rd), .hz_stall(hz_stall),
        .starve_req(starve_req),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called just after a falling edge with inputs applied; checks outputs, then advances the model.
    task automatic run_cycle();
        bit          a_eff;
        bit          pop;
        bit          ewe;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        logic [36:0] h;
        bit          estall;
        int          sz;
        #1;
        a_eff = a_valid && (a_addr != 0);
        sz    = mq.size();
        ewe = 0; ewa = 0; ewd = 0;
        if (a_eff) begin
            ewe = 1; ewa = a_addr; ewd = a_data;
        end else if (sz > 0) begin
            h   = mq[0];
            ewe = (h[36:32] != 0); ewa = h[36:32]; ewd = h[31:0];
        end
        estall = (hz_rs1 != 0 && pend[hz_rs1]) || (hz_rs2 != 0 && pend[hz_rs2]) ||
                 (hz_rd != 0 && pend[hz_rd]);
        check("b_ready", 32'(b_ready), 32'(sz < DEPTH));
        check("rf_we", 32'(rf_we), 32'(ewe));
        check("rf_wa", 32'(rf_wa), 32'(ewa));
        if (ewe || sz == 0 || a_eff) check("rf_wd", rf_wd, ewd);
        check("hz_stall", 32'(hz_stall), 32'(estall));
        check("starve_req", 32'(starve_req), 32'(scnt >= LIMIT));

        pop = !a_eff && sz > 0;
        if (rst) begin
            mq.delete();
            pend = '0;
            scnt = 0;
        end else begin
            scnt = (sz > 0 && a_eff) ? scnt + 1 : 0;
            if (pop) begin
                h = mq.pop_front();
                if (h[36:32] != 0) pend[h[36:32]] = 1'b0;
            end
            if (b_valid && (sz < DEPTH || pop)) mq.push_back({b_addr, b_data});
            if (iss_valid && iss_rd != 0) pend[iss_rd] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        iss_valid = 0; iss_rd = 0; hz_rs1 = 0; hz_rs2 = 0; hz_rd = 0;
    endtask

    initial begin
        pend = '0;
        scnt = 0;
        idle_inputs();
        rst = 1;
        @(negedge clk);
        run_cycle();
        rst = 0;
        run_cycle();

        a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
        run_cycle();
        a_addr = 0;
        run_cycle();

        idle_inputs();
        iss_valid = 1; iss_rd = 7;
        run_cycle();
        iss_valid = 0; hz_rs1 = 7; b_valid = 1; b_addr = 7; b_data = 32'h1234;
        run_cycle();
        b_valid = 0;
        run_cycle();
        run_cycle();

        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            a_valid = 1; a_addr = 2; a_data = i;
            b_valid = (i < 2); b_addr = 5'(i + 3); b_data = 32'h1234 + i;
            run_cycle();
        end
        idle_inputs();
        b_valid = 1; b_addr = 9; b_data = 32'h55;
        run_cycle();
        b_valid = 0;
        run_cycle();
        run_cycle();

        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(0, 249) == 0);
            a_valid = (scnt >= LIMIT) ? 1'b0 : ($urandom_range(0, 3) != 0);
            a_addr  = 5'($urandom_range(0, 7));
            a_data  = $urandom;
            b_valid = $urandom_range(0, 1);
            b_addr  = 5'($urandom_range(0, 7));
            b_data  = $urandom;
            iss_rd  = 5'($urandom_range(0, 7));
            iss_valid = !pend[iss_rd] && ($urandom_range(0, 2) == 0);
            hz_rs1  = 5'($urandom_range(0, 7));
            hz_rs2  = 5'($urandom_range(0, 7));
            hz_rd   = 5'($urandom_range(0, 7));
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
